// File: rtl/div8_seq.sv
// div8_seq: sequential 8-bit restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV8_SIGNED_EN for two's-complement operands (truncating division); default is unsigned.
module div8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dz
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] pr_q, pr_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             busy_q, done_q, dz_q;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] a_mag, b_mag, quot_fix, rem_fix;

`ifdef DIV8_SIGNED_EN
    logic qneg_q, rneg_q;

    assign a_mag    = a[WIDTH-1] ? -a : a;
    assign b_mag    = b[WIDTH-1] ? -b : b;
    assign quot_fix = qneg_q ? -dvd_d : dvd_d;
    assign rem_fix  = rneg_q ? -pr_d : pr_d;
`else
    assign a_mag    = a;
    assign b_mag    = b;
    assign quot_fix = dvd_d;
    assign rem_fix  = pr_d;
`endif

    // The stored remainder is always below the divisor, so the ninth bit of the
    // partial remainder only exists in the shifted/trial value.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch can be inferred.
        pr_d    = '0;
        dvd_d   = '0;
        shifted = {pr_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dsr_q};
        if (!trial[WIDTH]) begin
            pr_d  = trial[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
            pr_d  = shifted[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
    end

    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
`ifdef DIV8_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dsr_q  <= b_mag;
                        pr_q   <= '0;
                        dvd_q  <= a_mag;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
`ifdef DIV8_SIGNED_EN
                        qneg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        rneg_q <= a[WIDTH-1];
`endif
                        if (b == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= a;
                            dz_q    <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            dz_q    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    pr_q  <= pr_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        quot_q  <= quot_fix;
                        rem_q   <= rem_fix;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quot = quot_q;
    assign rem  = rem_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_div8_seq.sv
// tb_div8_seq: directed bench for div8_seq; expected results are queued at launch and checked at done.
// Builds for either setting of DIV8_SIGNED_EN.
module tb_div8_seq;
    typedef struct packed {
        logic [7:0] quot;
        logic [7:0] rem;
        logic       dz;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, dz;
    logic [7:0] quot, rem;

    res_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    div8_seq #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .quot (quot),
        .rem  (rem),
        .dz   (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference division with truncation toward zero; remainder follows the dividend.
    function automatic res_t model(input logic [7:0] x, input logic [7:0] y);
        res_t r;
        int   q, m;
        if (y == 8'd0) begin
            r.quot = 8'hFF;
            r.rem  = x;
            r.dz   = 1'b1;
            return r;
        end
`ifdef DIV8_SIGNED_EN
        q = int'($signed(x)) / int'($signed(y));
        m = int'($signed(x)) % int'($signed(y));
`else
        q = int'(x) / int'(y);
        m = int'(x) % int'(y);
`endif
        r.quot = q[7:0];
        r.rem  = m[7:0];
        r.dz   = 1'b0;
        return r;
    endfunction

    // Returns at the falling edge just after the accept edge.
    task automatic launch(input logic [7:0] x, input logic [7:0] y, input bit expect_res);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        if (expect_res) sb_q.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    // cyc0 is the number of cycles after the accept edge already elapsed on entry.
    task automatic await_done(input string tag, input int exp_lat, input int cyc0);
        int   cyc;
        res_t e;
        cyc = cyc0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        if (done) begin
            check({tag, "_sb"}, sb_q.size(), 1);
            e = sb_q.pop_front();
            check({tag, "_quot"}, quot, e.quot);
            check({tag, "_rem"}, rem, e.rem);
            check({tag, "_dz"}, dz, e.dz);
            check({tag, "_busy_done"}, busy, 1);
            @(negedge clk);
            check({tag, "_done_pulse"}, done, 0);
            check({tag, "_busy_idle"}, busy, 0);
        end
    endtask

    task automatic count_done(input string tag, input int ncyc);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int   t1, t2;
        res_t e;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quot", quot, 0);
        check("reset_rem", rem, 0);
        check("reset_dz", dz, 0);

        launch(8'd200, 8'd7, 1'b1);
        check("run_busy", busy, 1);
        await_done("d200_7", 9, 1);
        launch(8'd255, 8'd1, 1'b1);
        await_done("d255_1", 9, 1);
        launch(8'd5, 8'd9, 1'b1);
        await_done("d5_9", 9, 1);
        launch(8'd255, 8'd16, 1'b1);
        await_done("d255_16", 9, 1);

        launch(8'd37, 8'd0, 1'b1);
        await_done("d37_0", 1, 1);
        launch(8'd10, 8'd3, 1'b1);
        await_done("d10_3", 9, 1);

        // A second start during RUN must be dropped, not queued.
        launch(8'd50, 8'd6, 1'b1);
        repeat (3) @(negedge clk);
        a     = 8'd99;
        b     = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        await_done("repulse", 9, 5);
        count_done("repulse_no_second", 12);

        // Start held high: accepts land ten cycles apart.
        e  = model(8'd20, 8'd4);
        t1 = -1;
        t2 = -1;
        @(negedge clk);
        a     = 8'd20;
        b     = 8'd4;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
        end
        start = 1'b0;
        check("held_first_lat", t1, 8);
        check("held_period", t2 - t1, 10);
        check("held_quot", quot, e.quot);
        repeat (12) @(negedge clk);
        check("held_idle", busy, 0);

        // Reset at RUN iteration 4 discards the operation.
        launch(8'd77, 8'd5, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quot", quot, 0);
        check("midrst_rem", rem, 0);
        check("midrst_dz", dz, 0);
        count_done("midrst_no_done", 12);
        launch(8'd100, 8'd10, 1'b1);
        await_done("d100_10", 9, 1);

`ifdef DIV8_SIGNED_EN
        launch(8'hF9, 8'd2, 1'b1);
        await_done("s_m7_2", 9, 1);
        launch(8'd7, 8'hFE, 1'b1);
        await_done("s_7_m2", 9, 1);
        launch(8'h80, 8'hFF, 1'b1);
        await_done("s_m128_m1", 9, 1);
        launch(8'hF9, 8'd0, 1'b1);
        await_done("s_m7_0", 1, 1);
`endif

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
